// File: rtl/vga_pkg.sv
// Shared VGA scanout types and default 640x480@60 timing constants.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int FB_ADDR_W = 19;
  localparam int FB_PIXELS = DEF_H_ACTIVE * DEF_V_ACTIVE;
  localparam int CNT_W     = 10;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

endpackage

// File: rtl/vga_scanout_if.sv
// Framebuffer read port plus DAC/pin outputs of the scanout block.
interface vga_scanout_if;
  import vga_pkg::*;

  logic                 en;
  logic [FB_ADDR_W-1:0] rd_addr;
  rgb888_t              rd_data;
  logic [7:0]           vga_r;
  logic [7:0]           vga_g;
  logic [7:0]           vga_b;
  logic                 vga_hs;
  logic                 vga_vs;
  logic                 vga_de;
  logic                 vblank;
  logic                 frame_start;

  modport master (
    input  en, rd_data,
    output rd_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de, vblank, frame_start
  );

  modport slave (
    output en, rd_data,
    input  rd_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de, vblank, frame_start
  );

endinterface

// File: rtl/vga_timing_gen.sv
// Pixel-clock divider, raster h/v counters and stage-0 sync/enable decode.
// de/hs/vs are combinational from the counters (active-high); vblank and frame_start are registered.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 1,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic adv_o,
  output logic wrap_o,
  output logic de_o,
  output logic hs_o,
  output logic vs_o,
  output logic vblank_o,
  output logic frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [1:0] DIV_MAX = 2'(CLK_DIV - 1);
  localparam cnt_t H_ACT  = cnt_t'(H_ACTIVE);
  localparam cnt_t HS_BEG = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_END = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_ACT  = cnt_t'(V_ACTIVE);
  localparam cnt_t VS_BEG = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_END = cnt_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);

  logic [1:0] div_q, div_d;
  cnt_t       h_q, h_d, v_q, v_d;
  logic       vblank_q, fs_q;
  logic       pix_ce, h_wrap, v_wrap;

  always_comb begin
    pix_ce = en_i && (div_q == DIV_MAX);
    h_wrap = (h_q == H_LAST);
    v_wrap = (v_q == V_LAST);
    div_d  = div_q;
    h_d    = h_q;
    v_d    = v_q;
    if (!en_i) begin
      div_d = '0;
      h_d   = '0;
      v_d   = '0;
    end else begin
      div_d = pix_ce ? 2'd0 : div_q + 2'd1;
      if (pix_ce) begin
        h_d = h_wrap ? cnt_t'(0) : h_q + cnt_t'(1);
        if (h_wrap) begin
          v_d = v_wrap ? cnt_t'(0) : v_q + cnt_t'(1);
        end
      end
    end
  end

  // adv: the pixel the counters step onto is visible, so the address must follow it.
  assign adv_o  = pix_ce && (h_d < H_ACT) && (v_d < V_ACT);
  assign wrap_o = pix_ce && h_wrap && v_wrap;

  // Counters sit at (0,0) while disabled; gating by en keeps that from decoding as visible.
  assign de_o = en_i && (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_o = en_i && (h_q >= HS_BEG) && (h_q < HS_END);
  assign vs_o = en_i && (v_q >= VS_BEG) && (v_q < VS_END);

  assign vblank_o      = vblank_q;
  assign frame_start_o = fs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      h_q      <= '0;
      v_q      <= '0;
      vblank_q <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      div_q    <= div_d;
      h_q      <= h_d;
      v_q      <= v_d;
      vblank_q <= (v_q >= V_ACT);
      fs_q     <= wrap_o;
    end
  end

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: raster-order framebuffer addressing and RGB/sync output.
// rd_addr is stage 0; pins are 2 clk later, aligned with the 1-clk framebuffer read data.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 1,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SYNC_NEG = 1
) (
  input logic          clk,
  input logic          rst,
  vga_scanout_if.master bus
);

  localparam logic SYNC_IDLE = (SYNC_NEG != 0);

  logic adv, wrap, de0, hs0, vs0;

  vga_timing_gen #(
    .CLK_DIV (CLK_DIV),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk          (clk),
    .rst          (rst),
    .en_i         (bus.en),
    .adv_o        (adv),
    .wrap_o       (wrap),
    .de_o         (de0),
    .hs_o         (hs0),
    .vs_o         (vs0),
    .vblank_o     (bus.vblank),
    .frame_start_o(bus.frame_start)
  );

  logic [FB_ADDR_W-1:0] addr_q, addr_d;
  rgb888_t              rgb_q, rgb_d;
  logic                 de1_q, de2_q, hs1_q, hs2_q, vs1_q, vs2_q;

  // Running address: holds through blanking so the next visible pixel is simply +1.
  always_comb begin
    addr_d = addr_q;
    if (!bus.en || wrap) begin
      addr_d = '0;
    end else if (adv) begin
      addr_d = addr_q + FB_ADDR_W'(1);
    end
  end

  assign rgb_d = de1_q ? bus.rd_data : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      rgb_q  <= '0;
      de1_q  <= 1'b0;
      de2_q  <= 1'b0;
      hs1_q  <= SYNC_IDLE;
      hs2_q  <= SYNC_IDLE;
      vs1_q  <= SYNC_IDLE;
      vs2_q  <= SYNC_IDLE;
    end else begin
      addr_q <= addr_d;
      rgb_q  <= rgb_d;
      de1_q  <= de0;
      de2_q  <= de1_q;
      hs1_q  <= hs0 ^ SYNC_IDLE;
      hs2_q  <= hs1_q;
      vs1_q  <= vs0 ^ SYNC_IDLE;
      vs2_q  <= vs1_q;
    end
  end

  assign bus.rd_addr = addr_q;
  assign bus.vga_r   = rgb_q.r;
  assign bus.vga_g   = rgb_q.g;
  assign bus.vga_b   = rgb_q.b;
  assign bus.vga_de  = de2_q;
  assign bus.vga_hs  = hs2_q;
  assign bus.vga_vs  = vs2_q;

endmodule
